agc_servo: RTL
==============

Name: agc_servo

Overview:
- Closed-loop AGC controller that drives one agc_core instance in the ACLK domain.
- Each iteration issues an AGC tick and waits for the measurement window to finish. It then reads the square, above-threshold and below-threshold accumulators, computes a new scale and offset, loads them and applies them.
- It replaces the manual Wishbone tick/load/apply sequence with hardware iteration. The Wishbone side only sets the target and deadbands and reads status.

Parameters:
- SCALE_SHIFT, 8, arithmetic right shift applied to the power error before adding it to scale.
- INIT_SCALE, 17'h04000, scale value loaded on reset and on init_i.
- SETTLE_CYCLES, 16, idle clocks after apply before the next tick.
- TIMEOUT_CYCLES, 262144, maximum clocks in WAIT before the error flag is raised.
- LOCK_COUNT, 4, number of consecutive in-band iterations needed to assert locked.

Ports:
- clk_i  in  1  ACLK.
- rst_i  in  1  asynchronous active-high reset.
- enable_i  in  1  continuous iteration while high (level).
- single_i  in  1  one-cycle pulse requesting a single iteration.
- init_i  in  1  one-cycle pulse: reload INIT_SCALE and offset 0, and pulse agc_rst_o.
- target_i  in  24  target square-accumulator value.
- deadband_i  in  24  allowed |target_i - sq_accum_i| with no scale change.
- ofs_deadband_i  in  21  allowed |gt - lt| with no offset change.
- sq_accum_i  in  24  square accumulator from agc_core.
- gt_accum_i  in  21  above-threshold accumulator from agc_core.
- lt_accum_i  in  21  below-threshold accumulator from agc_core.
- agc_done_i  in  1  measurement-complete pulse; accumulators are valid when it is high.
- agc_tick_o  out  1  starts a measurement window.
- agc_rst_o  out  1  agc_core reset pulse.
- agc_scale_o  out  17  unsigned scale.
- agc_offset_o  out  8  two's-complement offset.
- agc_scale_ce_o  out  1  scale load strobe.
- agc_offset_ce_o  out  1  offset load strobe.
- agc_apply_o  out  1  apply strobe.
- busy_o  out  1  high whenever state is not IDLE.
- locked_o  out  1  loop locked.
- err_o  out  1  sticky timeout flag; cleared by init_i.
- iter_count_o  out  16  completed iterations; wraps at 16'hFFFF -> 0.

Behaviour:
- Clock, reset and output registering:
  - Single clock, clk_i. Reset is asynchronous and active-high, on rst_i.
  - Reset values: every strobe 0; agc_scale_o = INIT_SCALE; agc_offset_o = 0; busy_o, locked_o, err_o = 0; iter_count_o = 0; state IDLE.
  - All outputs are registered.
- IDLE:
  - init_i has priority over any start request. It loads INIT_SCALE and offset 0, pulses agc_rst_o for 1 cycle, clears err_o, clears the lock counter and locked_o, and stays in IDLE.
  - Otherwise enable_i or single_i moves to TICK. Both high together counts as one start.
  - init_i, single_i and agc_done_i are ignored in every state other than those listed here.
- TICK: agc_tick_o = 1 for exactly 1 cycle; clear the timeout counter; go to WAIT.
- WAIT:
  - agc_done_i moves to CALC and captures all three accumulators that same cycle.
  - If TIMEOUT_CYCLES elapse without agc_done_i: set err_o, clear locked_o, go to IDLE, and drop enable iteration until enable_i is seen low then high again.
- CALC (1 cycle), scale update:
  - e = target_i - sq_accum_i, 25-bit signed.
  - If |e| <= deadband_i: scale is unchanged.
  - Otherwise: scale_new = scale + (e >>> SCALE_SHIFT), computed at 19 bits signed and saturated to [0, 17'h1FFFF].
- CALC, offset update:
  - d = gt - lt, 22-bit signed.
  - If d > ofs_deadband_i: offset -= 1, saturating at -128.
  - If d < -ofs_deadband_i: offset += 1, saturating at +127.
- CALC, lock tracking:
  - The iteration is in-band when both deadband tests pass.
  - An in-band iteration increments the lock counter, which saturates at LOCK_COUNT. An out-of-band iteration clears it.
  - locked_o = (lock counter == LOCK_COUNT).
- LOAD: agc_scale_o and agc_offset_o already hold the new values; agc_scale_ce_o = agc_offset_ce_o = 1 for 1 cycle.
- APPLY:
  - agc_apply_o = 1 for 1 cycle; iter_count_o += 1.
  - Go to SETTLE.
- SETTLE:
  - Count SETTLE_CYCLES clocks, then go to IDLE.
  - With enable_i still high, IDLE proceeds to TICK on the next cycle, so one IDLE cycle falls between iterations.
- enable_i falling mid-iteration: the current iteration completes; no new one starts.
- locked_o also clears when enable_i is low in IDLE.
- rst_i mid-iteration: immediate return to reset values; an in-flight measurement is discarded.
- Latency from agc_done_i to agc_apply_o: 3 cycles (CALC, LOAD, APPLY).

Test Plan:
- Scale low: target 0x100000, sq 0x080000, deadband 0, scale 0x04000, SHIFT 8, single_i -> one tick; after done, scale = 0x04000 + 0x800 = 0x04800; ce strobes, apply, iter_count = 1.
- Saturation: scale 0x1FF00, e = +0x7FFFFF -> scale 0x1FFFF. Offset at -128 with d > deadband -> stays -128.
- Deadband and lock: sq within deadband and |gt - lt| <= ofs_deadband for 4 iterations under enable_i -> scale/offset unchanged, locked_o rises after the 4th apply. One out-of-band iteration -> locked_o falls.
- Timeout: TIMEOUT_CYCLES = 100, agc_done_i never asserted -> err_o = 1 at cycle 100 of WAIT, state IDLE, no ce/apply. init_i -> err_o = 0, agc_rst_o pulses, scale = INIT_SCALE.
- Reset mid-WAIT: assert rst_i asynchronously -> all outputs at reset values immediately; a later agc_done_i is ignored.
- Continuous run: enable_i held, SETTLE_CYCLES = 16 -> tick-to-tick spacing = window + 3 + 16 + 2 cycles; no double tick when single_i coincides with enable_i.

Source files
------------

// File: rtl/agc_servo_if.sv
// agc_servo_if: agc_core bus; master (servo) drives tick/rst/scale/offset/strobes, slave (core) returns done and the three accumulators
interface agc_servo_if;
  logic        agc_tick_o;
  logic        agc_rst_o;
  logic [16:0] agc_scale_o;
  logic [7:0]  agc_offset_o;
  logic        agc_scale_ce_o;
  logic        agc_offset_ce_o;
  logic        agc_apply_o;
  logic [23:0] sq_accum_i;
  logic [20:0] gt_accum_i;
  logic [20:0] lt_accum_i;
  logic        agc_done_i;
  modport master (
    output agc_tick_o, agc_rst_o, agc_scale_o, agc_offset_o, agc_scale_ce_o, agc_offset_ce_o, agc_apply_o,
    input  sq_accum_i, gt_accum_i, lt_accum_i, agc_done_i
  );
  modport slave (
    input  agc_tick_o, agc_rst_o, agc_scale_o, agc_offset_o, agc_scale_ce_o, agc_offset_ce_o, agc_apply_o,
    output sq_accum_i, gt_accum_i, lt_accum_i, agc_done_i
  );
endinterface

// File: rtl/agc_servo.sv
// agc_servo: closed-loop AGC iterator (tick, wait, calc, load, apply, settle); ports: clk_i/rst_i, enable/single/init controls, target/deadbands, agc_core bus (master), busy/locked/err/iter_count status
module agc_servo #(
  parameter int          SCALE_SHIFT    = 8,
  parameter logic [16:0] INIT_SCALE     = 17'h04000,
  parameter int          SETTLE_CYCLES  = 16,
  parameter int          TIMEOUT_CYCLES = 262144,
  parameter int          LOCK_COUNT     = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic        single_i,
  input  logic        init_i,
  input  logic [23:0] target_i,
  input  logic [23:0] deadband_i,
  input  logic [20:0] ofs_deadband_i,
  agc_servo_if.master core,
  output logic        busy_o,
  output logic        locked_o,
  output logic        err_o,
  output logic [15:0] iter_count_o
);
  localparam int CMAX = TIMEOUT_CYCLES > SETTLE_CYCLES ? TIMEOUT_CYCLES : SETTLE_CYCLES;
  localparam int CW = $clog2(CMAX) + 1;
  localparam int LW = $clog2(LOCK_COUNT + 1);
  typedef enum logic [2:0] {IDLE, TICK, WAIT, CALC, LOAD, APPLY, SETTLE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] lock_q, lock_d;
  logic [16:0] scale_q, scale_d, scale_n;
  logic [7:0] ofs_q, ofs_d;
  logic [23:0] sq_q, sq_d;
  logic [20:0] gt_q, gt_d, lt_q, lt_d;
  logic [15:0] iter_q, iter_d;
  logic tick_q, tick_d, arst_q, arst_d, ce_q, ce_d, apply_q, apply_d;
  logic busy_q, busy_d, locked_q, locked_d, err_q, err_d, blk_q, blk_d;
  logic signed [25:0] e, e_abs, sum;
  logic signed [21:0] d, odb;
  logic in_s, d_hi, d_lo;
  always_comb begin
    e = $signed({2'b0, target_i}) - $signed({2'b0, sq_q});
    e_abs = e[25] ? -e : e;
    in_s = e_abs <= $signed({2'b0, deadband_i});
    sum = $signed({9'b0, scale_q}) + (e >>> SCALE_SHIFT);
    scale_n = sum[25] ? 17'd0 : (|sum[24:17]) ? 17'h1FFFF : sum[16:0];
    d = $signed({1'b0, gt_q}) - $signed({1'b0, lt_q});
    odb = $signed({1'b0, ofs_deadband_i});
    d_hi = d > odb;
    d_lo = d < -odb;
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    lock_d = lock_q;
    scale_d = scale_q;
    ofs_d = ofs_q;
    sq_d = sq_q;
    gt_d = gt_q;
    lt_d = lt_q;
    iter_d = iter_q;
    err_d = err_q;
    arst_d = 1'b0;
    // a timeout blocks enable-driven restarts until enable_i is seen low
    blk_d = blk_q & enable_i;
    case (state_q)
      IDLE:
        if (init_i) begin
          scale_d = INIT_SCALE;
          ofs_d = '0;
          arst_d = 1'b1;
          err_d = 1'b0;
          lock_d = '0;
        end else begin
          lock_d = enable_i ? lock_q : '0;
          state_d = ((enable_i && !blk_q) || single_i) ? TICK : IDLE;
        end
      TICK: begin
        cnt_d = '0;
        state_d = WAIT;
      end
      WAIT:
        if (core.agc_done_i) begin
          sq_d = core.sq_accum_i;
          gt_d = core.gt_accum_i;
          lt_d = core.lt_accum_i;
          state_d = CALC;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          err_d = 1'b1;
          lock_d = '0;
          blk_d = 1'b1;
          state_d = IDLE;
        end else
          cnt_d = cnt_q + 1'b1;
      CALC: begin
        scale_d = in_s ? scale_q : scale_n;
        ofs_d = (d_hi && ofs_q != 8'h80) ? ofs_q - 8'd1 : (d_lo && ofs_q != 8'h7F) ? ofs_q + 8'd1 : ofs_q;
        lock_d = (in_s && !d_hi && !d_lo) ? ((lock_q == LW'(LOCK_COUNT)) ? lock_q : lock_q + 1'b1) : '0;
        state_d = LOAD;
      end
      LOAD: begin
        iter_d = iter_q + 16'd1;
        cnt_d = '0;
        state_d = APPLY;
      end
      APPLY: state_d = SETTLE;
      SETTLE:
        if (cnt_q == CW'(SETTLE_CYCLES - 1))
          state_d = IDLE;
        else
          cnt_d = cnt_q + 1'b1;
      default: state_d = IDLE;
    endcase
    // strobes decode the next state so every output comes straight from a flop
    tick_d = state_d == TICK;
    ce_d = state_d == LOAD;
    apply_d = state_d == APPLY;
    busy_d = state_d != IDLE;
    locked_d = lock_d == LW'(LOCK_COUNT);
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q <= '0;
      lock_q <= '0;
      scale_q <= INIT_SCALE;
      ofs_q <= '0;
      sq_q <= '0;
      gt_q <= '0;
      lt_q <= '0;
      iter_q <= '0;
      tick_q <= 1'b0;
      arst_q <= 1'b0;
      ce_q <= 1'b0;
      apply_q <= 1'b0;
      busy_q <= 1'b0;
      locked_q <= 1'b0;
      err_q <= 1'b0;
      blk_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      lock_q <= lock_d;
      scale_q <= scale_d;
      ofs_q <= ofs_d;
      sq_q <= sq_d;
      gt_q <= gt_d;
      lt_q <= lt_d;
      iter_q <= iter_d;
      tick_q <= tick_d;
      arst_q <= arst_d;
      ce_q <= ce_d;
      apply_q <= apply_d;
      busy_q <= busy_d;
      locked_q <= locked_d;
      err_q <= err_d;
      blk_q <= blk_d;
    end
  assign core.agc_tick_o = tick_q;
  assign core.agc_rst_o = arst_q;
  assign core.agc_scale_o = scale_q;
  assign core.agc_offset_o = ofs_q;
  assign core.agc_scale_ce_o = ce_q;
  assign core.agc_offset_ce_o = ce_q;
  assign core.agc_apply_o = apply_q;
  assign busy_o = busy_q;
  assign locked_o = locked_q;
  assign err_o = err_q;
  assign iter_count_o = iter_q;
endmodule
